// File: rtl/pipe_sel_reg.sv
// pipe_sel_reg: N-way binary-indexed operand select feeding one registered pipeline stage.
// Defining PIPE_SEL_ERR_EN adds the sticky out-of-range flag output sel_err.
module pipe_sel_reg #(
    parameter int               WIDTH     = 32,
    parameter int               NUM_IN    = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    localparam int              SEL_W     = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    input  logic                    stall,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
`ifdef PIPE_SEL_ERR_EN
    output logic                    sel_err,
`endif
    output logic [SEL_W-1:0]        out_sel
);

    logic [WIDTH-1:0] operand_s [NUM_IN];
    logic             sel_in_range_s;
    logic [WIDTH-1:0] picked_s;
    logic             load_s;

    logic [WIDTH-1:0] data_d,  data_q;
    logic             valid_d, valid_q;
    logic [SEL_W-1:0] sel_d,   sel_q;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_unpack
        assign operand_s[i] = in_data[i*WIDTH +: WIDTH];
    end

    // Plain indexed mux; indices past NUM_IN select zero.
    always_comb begin
        sel_in_range_s = (int'(sel) < NUM_IN);
        picked_s       = {WIDTH{1'b0}};
        if (sel_in_range_s) begin
            picked_s = operand_s[sel];
        end else begin
            picked_s = {WIDTH{1'b0}};
        end
    end

    assign load_s = !flush && !stall;

    // Next-state for the stage register: flush beats stall beats load.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        sel_d   = sel_q;
        if (flush) begin
            data_d  = RESET_VAL;
            valid_d = 1'b0;
            sel_d   = {SEL_W{1'b0}};
        end else if (stall) begin
            data_d  = data_q;
            valid_d = valid_q;
            sel_d   = sel_q;
        end else begin
            valid_d = in_valid;
            sel_d   = sel;
            if (in_valid) begin
                data_d = picked_s;
            end else begin
                data_d = data_q;
            end
        end
    end

    // Stage register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= RESET_VAL;
            valid_q <= 1'b0;
            sel_q   <= {SEL_W{1'b0}};
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            sel_q   <= sel_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_sel   = sel_q;

`ifdef PIPE_SEL_ERR_EN
    logic err_d, err_q;

    // Sticky: only reset_n clears it, flush and stall leave it alone.
    always_comb begin
        err_d = err_q;
        if (load_s && in_valid && !sel_in_range_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Error flag register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign sel_err = err_q;
`endif

endmodule
